// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch channel: the sequencer (master) drives address and request,
// memory (slave) answers with ack and the instruction word.
interface fetch_sequencer_if #(
  parameter int CNTR_WIDTH    = 8,
  parameter int COMBINED_DATA = 24
);
  logic [CNTR_WIDTH-1:0]    imem_addr;
  logic                     imem_req;
  logic                     imem_ack;
  logic [COMBINED_DATA-1:0] imem_data;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller for the accumulator core: owns pc and ir,
// fetches over the imem channel and confines decoder load/store to the EXEC cycle.
module fetch_sequencer #(
  parameter int CNTR_WIDTH    = 8,
  parameter int COMBINED_DATA = 24,
  parameter int RET_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  fetch_sequencer_if.master        imem,
  output logic [COMBINED_DATA-1:0] ir,
  input  logic                     jmp,
  input  logic                     rst_f,
  input  logic                     load,
  input  logic                     store,
  output logic                     accu_en,
  output logic                     reg_we,
  output logic [1:0]               state,
  output logic [RET_WIDTH-1:0]     retired
);

  // state  | meaning
  // IDLE   | stopped at an instruction boundary, waiting for run
  // FETCH  | imem_req held until imem_ack, word latched into ir
  // DECODE | settle cycle for the decoder on the new ir
  // EXEC   | one-cycle write enables, pc update, retire count
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CNTR_WIDTH-1:0]    pc_q, pc_d;
  logic [COMBINED_DATA-1:0] ir_q, ir_d;
  logic [RET_WIDTH-1:0]     retired_q, retired_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    retired_d     = retired_q;
    imem.imem_req = 1'b0;
    accu_en       = 1'b0;
    reg_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          ir_d    = imem.imem_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        accu_en = load;
        reg_we  = store;
        if (retired_q != {RET_WIDTH{1'b1}}) retired_d = retired_q + 1'b1;
        // Soft reset outranks a jump; the RST word itself is cleared from ir.
        if (!rst_f) begin
          pc_d = '0;
          ir_d = '0;
        end else if (jmp) begin
          pc_d = ir_q[CNTR_WIDTH-1:0];
        end else begin
          pc_d = pc_q + 1'b1;
        end
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign ir             = ir_q;
  assign state          = state_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written corner
// sequences, and a randomized run compared against an instruction-level reference model.
module tb_fetch_sequencer;
  localparam int CW      = 8;
  localparam int DW      = 24;
  localparam int RW      = 4;
  localparam int RET_MAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst, run, ack, jmp, rst_f, load, store;
  logic [DW-1:0] data;
  logic [DW-1:0] ir;
  logic          accu_en, reg_we;
  logic [1:0]    state;
  logic [RW-1:0] retired;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model: state code, pc, ir and retired count as plain integers
  int m_st, m_pc, m_ir, m_ret;

  fetch_sequencer_if #(.CNTR_WIDTH(CW), .COMBINED_DATA(DW)) imem_if ();
  assign imem_if.imem_ack  = ack;
  assign imem_if.imem_data = data;

  fetch_sequencer #(.CNTR_WIDTH(CW), .COMBINED_DATA(DW), .RET_WIDTH(RW)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .imem    (imem_if),
    .ir      (ir),
    .jmp     (jmp),
    .rst_f   (rst_f),
    .load    (load),
    .store   (store),
    .accu_en (accu_en),
    .reg_we  (reg_we),
    .state   (state),
    .retired (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int run, ack, data, jmp, rst_f, load, store;
    int e_st, e_req, e_addr, e_accu, e_reg, e_ir, e_ret;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_st = 0; m_pc = 0; m_ir = 0; m_ret = 0;
    end else begin
      case (m_st)
        0: if (run) m_st = 1;
        1: if (ack) begin m_ir = int'(data); m_st = 2; end
        2: m_st = 3;
        default: begin
          m_ret = (m_ret < RET_MAX) ? m_ret + 1 : RET_MAX;
          if (!rst_f) begin
            m_pc = 0;
            m_ir = 0;
          end else if (jmp) begin
            m_pc = m_ir % 256;
          end else begin
            m_pc = (m_pc + 1) % 256;
          end
          m_st = run ? 1 : 0;
        end
      endcase
    end
  endtask

  task automatic step();
    #2;
    if (chk_en) begin
      chk("model_state", 32'(state), 32'(m_st));
      chk("model_req", 32'(imem_if.imem_req), 32'(m_st == 1));
      chk("model_addr", 32'(imem_if.imem_addr), 32'(m_pc));
      chk("model_accu_en", 32'(accu_en), 32'((m_st == 3) && load));
      chk("model_reg_we", 32'(reg_we), 32'((m_st == 3) && store));
      chk("model_ir", 32'(ir), 32'(m_ir));
      chk("model_retired", 32'(retired), 32'(m_ret));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; run = 1'b0; ack = 1'b0; data = '0;
    jmp = 1'b0; rst_f = 1'b1; load = 1'b0; store = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH (run_after=1) or IDLE.
  task automatic do_instr(input logic [DW-1:0] word, input int waits, input logic j,
                          input logic rf, input logic ld, input logic stv, input logic run_after);
    run = 1'b1;
    ack = 1'b0;
    for (int w = 0; w < waits; w++) step();
    ack = 1'b1; data = word;
    step();
    ack = 1'b0; data = '0;
    jmp = j; rst_f = rf; load = ld; store = stv; run = run_after;
    step();
    step();
    jmp = 1'b0; rst_f = 1'b1; load = 1'b0; store = 1'b0;
  endtask

  vec_t vecs[24];

  initial begin
    int req_cycles;

    vecs = '{
      '{1,0,0,        0,1,0,0, 0,0,8'h00,0,0,24'h000000,0},
      '{1,1,24'h200000,0,1,0,0, 1,1,8'h00,0,0,24'h000000,0},
      '{1,1,24'hFFFFFF,0,1,0,1, 2,0,8'h00,0,0,24'h200000,0},
      '{1,0,0,        0,1,0,1, 3,0,8'h00,0,1,24'h200000,0},
      '{1,1,24'h100000,0,1,0,0, 1,1,8'h01,0,0,24'h200000,1},
      '{1,0,0,        0,1,1,0, 2,0,8'h01,0,0,24'h100000,1},
      '{1,0,0,        0,1,1,0, 3,0,8'h01,1,0,24'h100000,1},
      '{1,1,24'h0ABCDE,0,1,0,0, 1,1,8'h02,0,0,24'h100000,2},
      '{1,0,0,        0,1,0,0, 2,0,8'h02,0,0,24'h0ABCDE,2},
      '{0,0,0,        0,1,0,0, 3,0,8'h02,0,0,24'h0ABCDE,2},
      '{0,1,24'h123456,0,1,0,0, 0,0,8'h03,0,0,24'h0ABCDE,3},
      '{1,0,0,        0,1,0,0, 0,0,8'h03,0,0,24'h0ABCDE,3},
      '{1,1,24'h300040,0,1,0,0, 1,1,8'h03,0,0,24'h0ABCDE,3},
      '{1,0,0,        1,1,0,0, 2,0,8'h03,0,0,24'h300040,3},
      '{1,0,0,        1,1,0,0, 3,0,8'h03,0,0,24'h300040,3},
      '{1,1,24'h500000,0,1,0,0, 1,1,8'h40,0,0,24'h300040,4},
      '{1,0,0,        0,0,0,0, 2,0,8'h40,0,0,24'h500000,4},
      '{1,0,0,        0,0,0,0, 3,0,8'h40,0,0,24'h500000,4},
      '{1,0,0,        0,1,0,0, 1,1,8'h00,0,0,24'h000000,5},
      '{1,0,0,        0,1,0,0, 1,1,8'h00,0,0,24'h000000,5},
      '{1,1,24'h0ABCDE,0,1,0,0, 1,1,8'h00,0,0,24'h000000,5},
      '{0,0,0,        0,1,0,0, 2,0,8'h00,0,0,24'h0ABCDE,5},
      '{0,0,0,        0,1,0,0, 3,0,8'h00,0,0,24'h0ABCDE,5},
      '{0,0,0,        0,1,0,0, 0,0,8'h01,0,0,24'h0ABCDE,6}
    };

    m_st = 0; m_pc = 0; m_ir = 0; m_ret = 0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_addr", 32'(imem_if.imem_addr), 0);
    chk("rst_req", 32'(imem_if.imem_req), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_retired", 32'(retired), 0);

    for (int i = 0; i < 24; i++) begin
      run   = vecs[i].run[0];
      ack   = vecs[i].ack[0];
      data  = vecs[i].data[DW-1:0];
      jmp   = vecs[i].jmp[0];
      rst_f = vecs[i].rst_f[0];
      load  = vecs[i].load[0];
      store = vecs[i].store[0];
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), vecs[i].e_st);
      chk($sformatf("vec%0d_req", i), 32'(imem_if.imem_req), vecs[i].e_req);
      chk($sformatf("vec%0d_addr", i), 32'(imem_if.imem_addr), vecs[i].e_addr);
      chk($sformatf("vec%0d_accu_en", i), 32'(accu_en), vecs[i].e_accu);
      chk($sformatf("vec%0d_reg_we", i), 32'(reg_we), vecs[i].e_reg);
      chk($sformatf("vec%0d_ir", i), 32'(ir), vecs[i].e_ir);
      chk($sformatf("vec%0d_retired", i), 32'(retired), vecs[i].e_ret);
      step();
    end

    // two wait cycles: req held three cycles, ir only moves on the ack
    do_reset();
    run = 1'b1;
    step();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      ack  = (i == 2);
      data = (i == 2) ? 24'h0C0FFE : 24'h777777;
      #1;
      if (imem_if.imem_req) req_cycles++;
      chk("wait_ir_hold", 32'(ir), 0);
      step();
    end
    chk("wait_req_cycles", 32'(req_cycles), 3);
    chk("wait_ir_on_ack", 32'(ir), 32'h0C0FFE);
    ack = 1'b0;
    step();
    step();
    chk("wait_next_fetch_state", 32'(state), 1);
    chk("wait_next_fetch_addr", 32'(imem_if.imem_addr), 1);

    // reset while waiting in FETCH, then a late ack
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; run = 1'b0;
    chk("fetch_rst_state", 32'(state), 0);
    chk("fetch_rst_req", 32'(imem_if.imem_req), 0);
    ack = 1'b1; data = 24'h123456;
    step();
    chk("late_ack_ir", 32'(ir), 0);
    chk("late_ack_state", 32'(state), 0);

    // jumps: taken at pc=5 and not taken at pc=5
    do_reset();
    run = 1'b1;
    step();
    do_instr(24'h000005, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pc_at_5", 32'(imem_if.imem_addr), 5);
    do_instr(24'h300040, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("jmp_target_40", 32'(imem_if.imem_addr), 32'h40);
    do_instr(24'h000005, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_instr(24'h400077, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cond_jmp_false", 32'(imem_if.imem_addr), 6);

    // pc wrap from 0xFF
    do_instr(24'h0000FF, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pc_at_ff", 32'(imem_if.imem_addr), 32'hFF);
    do_instr(24'h000000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pc_wrap", 32'(imem_if.imem_addr), 0);

    // soft reset opcode at 0x10 keeps running
    do_instr(24'h000010, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_instr(24'h500000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("soft_rst_addr", 32'(imem_if.imem_addr), 0);
    chk("soft_rst_ir", 32'(ir), 0);
    chk("soft_rst_state", 32'(state), 1);

    // run dropped in DECODE: EXEC completes, stop with pc+1
    do_instr(24'h000000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("run_drop_state", 32'(state), 0);
    chk("run_drop_addr", 32'(imem_if.imem_addr), 1);

    // retired saturation
    do_reset();
    run = 1'b1;
    step();
    for (int i = 0; i < 20; i++) do_instr(24'h000000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("retired_saturated", 32'(retired), RET_MAX);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      run   = ($urandom_range(0, 9) < 8);
      ack   = 1'($urandom_range(0, 1));
      data  = 24'($urandom);
      jmp   = 1'($urandom_range(0, 1));
      rst_f = ($urandom_range(0, 7) != 0);
      load  = 1'($urandom_range(0, 1));
      store = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/decode/execute controller for the accumulator CPU core. It owns the program counter and the instruction register, and fetches instruction words over a req/ack handshake. It presents the latched instruction to `instruction_decoder` and turns the decoder's `load`/`store` outputs into single-cycle write enables. It also applies the decoder's `jmp`/`rst_f` outcome to the program counter. It sits between instruction memory and the decoder/accumulator/register file.

## Interface
- CNTR_WIDTH, 8, program counter / instruction address width
- COMBINED_DATA, 24, instruction word width; jump target = ir[CNTR_WIDTH-1:0]
- RET_WIDTH, 16, retired-instruction counter width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
- imem_addr  out  CNTR_WIDTH  fetch address (= pc)
- imem_req  out  1  fetch request, high for the whole FETCH state
- imem_ack  in  1  memory returns imem_data valid this cycle
- imem_data  in  COMBINED_DATA  instruction word
- ir  out  COMBINED_DATA  instruction register, drives decoder data_in
- jmp  in  1  decoder: take jump
- rst_f  in  1  decoder: 0 = RST opcode (soft reset)
- load  in  1  decoder: accumulator load
- store  in  1  decoder: register-file store
- accu_en  out  1  accumulator write enable, one cycle
- reg_we  out  1  register-file write enable, one cycle
- state  out  2  IDLE=0, FETCH=1, DECODE=2, EXEC=3
- retired  out  RET_WIDTH  count of completed EXEC cycles, saturating

## Operation
- Reset (rst=1 at an edge): state=IDLE, pc=0, ir=0, retired=0. In the same cycle the outputs are imem_req=0, accu_en=0, reg_we=0 and imem_addr=0. Reset overrides every state, including mid-fetch; an outstanding req is dropped, and an ack on a later cycle is ignored.
- IDLE: all enables 0. If run=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc. The request is held until imem_ack=1, with no timeout and no abort when run falls. On ack: ir<=imem_data, go to DECODE.
- DECODE: one settle cycle. The decoder evaluates the new ir combinationally together with the current flags. No enables are asserted. Go to EXEC.
- EXEC: accu_en=load, reg_we=store for exactly this cycle. retired<=retired+1, saturating at all-ones. The PC update follows this priority:
  - rst_f=0: pc<=0, ir<=0.
  - else jmp=1: pc<=ir[CNTR_WIDTH-1:0].
  - else: pc<=pc+1, wrapping from 2^CNTR_WIDTH-1 to 0.
- EXEC next state: run=1 goes to FETCH; run=0 goes to IDLE. A RST instruction does not stop execution by itself.
- imem_ack outside FETCH is ignored and ir is unchanged.
- accu_en and reg_we are never high outside EXEC, regardless of decoder outputs. They may both be high only if the decoder drives both, which it never does by encoding.
- run is sampled only in IDLE and EXEC. A run pulse that falls before being sampled has no effect.

## Timing
- imem_req, imem_addr, accu_en and reg_we are combinational from the state/pc/ir registers and the decoder inputs. They have no extra register stage.
- With a zero-wait memory (ack in the same cycle as req), one instruction takes 3 cycles: FETCH, DECODE, EXEC. Each wait cycle adds 1.
- Start latency: run seen in IDLE at edge N, imem_req high in cycle N+1.
- A jump target is fetched in the FETCH state immediately after EXEC; there are no delay slots.
- The pc, ir and retired updates in EXEC take effect at the end of the EXEC cycle.
- If rst is asserted in EXEC, the reset values win and no retired increment occurs.

## Test plan
- Reset, then run=1 with zero-wait memory holding ST, LD, NOP at addresses 0–2. Required:
  - imem_addr sequence 0,1,2, with state 1,2,3 repeating.
  - reg_we high only in the first EXEC, accu_en only in the second.
  - retired=3 after 9 cycles.
- Memory with 2 wait cycles: imem_req is held for 3 cycles per fetch; ir changes only on the ack cycle; 5 cycles per instruction.
- JMP with ir[7:0]=0x40 at pc=5: the next imem_addr is 0x40. A conditional jump with its flag false at pc=5 gives imem_addr 6.
- pc=0xFF executing NOP: the next fetch uses address 0x00. A RST opcode at pc=0x10 gives next address 0, ir=0, and execution continues while run=1.
- Reset and run timing:
  - rst asserted while waiting in FETCH: the next cycle has state=0 and imem_req=0, and a late ack leaves ir=0.
  - run dropped in the DECODE cycle: EXEC completes, then state=IDLE with pc advanced by 1.
- Force retired to all-ones (via long run or small RET_WIDTH=2): further instructions keep retired at 3.
